// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared types and constants for the intersection sequencer:
//   - tl_state_e : phase-machine states
//   - tl_phase_e : wait/run phase of the interval timer
//   - INT_*      : interval select codes sent to the time-parameter block
//   - LAMP_*     : one-hot {R,Y,G} lamp encodings
// Build option: TL_LONG_MAIN_EN removes MAIN_G2 from the state set (main green
// is a single double-length phase).
// -----------------------------------------------------------------------------
package tl_pkg;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;
    localparam logic [1:0] INT_DBL  = 2'b11;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

`ifdef TL_LONG_MAIN_EN
    typedef enum logic [2:0] {
        MAIN_G1, MAIN_GX, MAIN_Y, PED_WALK, SIDE_G, SIDE_GX, SIDE_Y
    } tl_state_e;
`else
    typedef enum logic [2:0] {
        MAIN_G1, MAIN_G2, MAIN_GX, MAIN_Y, PED_WALK, SIDE_G, SIDE_GX, SIDE_Y
    } tl_state_e;
`endif

    typedef enum logic {
        PH_WAIT,
        PH_RUN
    } tl_phase_e;

endpackage

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Per-phase countdown. After a restart or an expiry it spends WAIT_CYC clocks
// waiting for the time-parameter lookup to settle (ticks ignored), loads
// load_value (0 is treated as 1), then decrements on each tick. The tick that
// finds the counter at 1 raises expire for that cycle and re-enters the wait.
// Ports:
//   clk        in   system clock
//   restart    in   synchronous restart (reset or reprogram), highest priority
//   tick       in   1 Hz enable
//   load_value in   duration for the phase just entered
//   expire     out  combinational one-cycle pulse on the expiring tick
// -----------------------------------------------------------------------------
module interval_timer
    import tl_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic             clk,
    input  logic             restart,
    input  logic             tick,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    localparam int             WAIT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);

    tl_phase_e         phase_q, phase_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        phase_d    = phase_q;
        wait_cnt_d = wait_cnt_q;
        cnt_d      = cnt_q;
        expire     = 1'b0;

        if (restart) begin
            phase_d    = PH_WAIT;
            wait_cnt_d = '0;
            cnt_d      = '0;
        end else if (phase_q == PH_WAIT) begin
            if (wait_cnt_q == WAIT_LAST) begin
                phase_d    = PH_RUN;
                wait_cnt_d = '0;
                cnt_d      = (load_value == '0) ? CNT_W'(1) : load_value;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
                expire     = 1'b1;
                phase_d    = PH_WAIT;
                wait_cnt_d = '0;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        phase_q    <= phase_d;
        wait_cnt_q <= wait_cnt_d;
        cnt_q      <= cnt_d;
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
// Main sequencer of the intersection controller. Steps the main/side/walk
// phase machine, drives the interval select to the time-parameter block, times
// each phase with interval_timer and drives the registered lamp outputs.
// Ports:
//   clk           in   system clock
//   Reset         in   synchronous active-high reset
//   one_hz_enable in   1 Hz tick
//   Sensor_Sync   in   side-street vehicle sensor (sampled on expiry only)
//   WR            in   latched walk request (sampled on MAIN_Y expiry only)
//   Prog_Sync     in   reprogram pulse, same effect as Reset
//   value         in   duration of the current interval
//   interval      out  interval select: 00 base, 01 ext, 10 yellow, 11 2*base
//   WR_Reset      out  one-cycle pulse on entry to PED_WALK, clears walk latch
//   main_lights   out  {R,Y,G} main street
//   side_lights   out  {R,Y,G} side street
//   walk          out  pedestrian walk lamp
// Build option: TL_LONG_MAIN_EN merges main green into one MAIN_G1 phase
// timed by interval 11.
// -----------------------------------------------------------------------------
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             one_hz_enable,
    input  logic             Sensor_Sync,
    input  logic             WR,
    input  logic             Prog_Sync,
    input  logic [CNT_W-1:0] value,
    output logic [1:0]       interval,
    output logic             WR_Reset,
    output logic [2:0]       main_lights,
    output logic [2:0]       side_lights,
    output logic             walk
);

    tl_state_e  state_q, state_d;
    logic [1:0] interval_q, interval_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_q, walk_d;
    logic       wr_reset_q, wr_reset_d;
    logic       restart;
    logic       expire;

    assign restart = Reset | Prog_Sync;

    // Expire is combinational, so the state advances on the same edge as the
    // final tick and the timer re-enters its wait on that edge too.
    interval_timer #(
        .CNT_W   (CNT_W),
        .WAIT_CYC(WAIT_CYC)
    ) u_timer (
        .clk       (clk),
        .restart   (restart),
        .tick      (one_hz_enable),
        .load_value(value),
        .expire    (expire)
    );

    // Next state.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = MAIN_G1;
        end else if (expire) begin
            case (state_q)
`ifdef TL_LONG_MAIN_EN
                MAIN_G1:  state_d = Sensor_Sync ? MAIN_GX : MAIN_Y;
`else
                MAIN_G1:  state_d = MAIN_G2;
                MAIN_G2:  state_d = Sensor_Sync ? MAIN_GX : MAIN_Y;
`endif
                MAIN_GX:  state_d = MAIN_Y;
                MAIN_Y:   state_d = WR ? PED_WALK : SIDE_G;
                PED_WALK: state_d = SIDE_G;
                SIDE_G:   state_d = Sensor_Sync ? SIDE_GX : SIDE_Y;
                SIDE_GX:  state_d = SIDE_Y;
                SIDE_Y:   state_d = MAIN_G1;
                default:  state_d = MAIN_G1;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered lamps and
    // interval change on the same edge as the state itself.
    always_comb begin
        interval_d = INT_BASE;
        main_d     = LAMP_G;
        side_d     = LAMP_R;
        walk_d     = 1'b0;
        case (state_d)
`ifdef TL_LONG_MAIN_EN
            MAIN_G1:  interval_d = INT_DBL;
`else
            MAIN_G1:  interval_d = INT_BASE;
            MAIN_G2:  interval_d = INT_BASE;
`endif
            MAIN_GX:  interval_d = INT_EXT;
            MAIN_Y: begin
                interval_d = INT_YEL;
                main_d     = LAMP_Y;
            end
            PED_WALK: begin
                interval_d = INT_EXT;
                main_d     = LAMP_R;
                walk_d     = 1'b1;
            end
            SIDE_G: begin
                main_d = LAMP_R;
                side_d = LAMP_G;
            end
            SIDE_GX: begin
                interval_d = INT_EXT;
                main_d     = LAMP_R;
                side_d     = LAMP_G;
            end
            SIDE_Y: begin
                interval_d = INT_YEL;
                main_d     = LAMP_R;
                side_d     = LAMP_Y;
            end
            default: ;
        endcase
        wr_reset_d = (state_d == PED_WALK) && (state_q != PED_WALK);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= MAIN_G1;
            interval_q <= INT_BASE;
            main_q     <= LAMP_G;
            side_q     <= LAMP_R;
            walk_q     <= 1'b0;
            wr_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            main_q     <= main_d;
            side_q     <= side_d;
            walk_q     <= walk_d;
            wr_reset_q <= wr_reset_d;
        end
    end

    assign interval    = interval_q;
    assign WR_Reset    = wr_reset_q;
    assign main_lights = main_q;
    assign side_lights = side_q;
    assign walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_fsm
// Drives traffic_light_fsm with directed and $urandom stimulus and compares
// every output each cycle against a table-driven phase model. The bench also
// stands in for the time-parameter block (registered lookup of interval) and
// the external walk-request latch.
// -----------------------------------------------------------------------------
module tb_traffic_light_fsm;

    localparam int CNT_W    = 4;
    localparam int WAIT_CYC = 2;

    logic             clk = 1'b0;
    logic             Reset;
    logic             one_hz_enable;
    logic             Sensor_Sync;
    logic             WR;
    logic             Prog_Sync;
    logic [CNT_W-1:0] value;
    logic [1:0]       interval;
    logic             WR_Reset;
    logic [2:0]       main_lights;
    logic [2:0]       side_lights;
    logic             walk;

    always #5 clk = ~clk;

    traffic_light_fsm #(.CNT_W(CNT_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .one_hz_enable(one_hz_enable),
        .Sensor_Sync  (Sensor_Sync),
        .WR           (WR),
        .Prog_Sync    (Prog_Sync),
        .value        (value),
        .interval     (interval),
        .WR_Reset     (WR_Reset),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk)
    );

    // ---------------- environment: time-parameter block and walk latch -------
    int   t_base = 6;
    int   t_ext  = 3;
    int   t_yel  = 2;
    logic wr_req = 1'b0;

    function automatic logic [CNT_W-1:0] lookup(input logic [1:0] sel);
        case (sel)
            2'b01:   return CNT_W'(t_ext);
            2'b10:   return CNT_W'(t_yel);
            2'b11:   return CNT_W'(2 * t_base);
            default: return CNT_W'(t_base);
        endcase
    endfunction

    always @(posedge clk) value <= lookup(interval);

    always @(posedge clk) begin
        if (wr_req)        WR <= 1'b1;
        else if (WR_Reset) WR <= 1'b0;
        else if (Reset)    WR <= 1'b0;
    end

    // ---------------- reference model ---------------------------------------
    localparam int P_G1 = 0, P_G2 = 1, P_GX = 2, P_Y = 3;
    localparam int P_PED = 4, P_SG = 5, P_SGX = 6, P_SY = 7;

    logic [2:0] tab_main [8] = '{3'b001, 3'b001, 3'b001, 3'b010,
                                 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] tab_side [8] = '{3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b100, 3'b001, 3'b001, 3'b010};
`ifdef TL_LONG_MAIN_EN
    logic [1:0] tab_int  [8] = '{2'b11, 2'b00, 2'b01, 2'b10,
                                 2'b01, 2'b00, 2'b01, 2'b10};
`else
    logic [1:0] tab_int  [8] = '{2'b00, 2'b00, 2'b01, 2'b10,
                                 2'b01, 2'b00, 2'b01, 2'b10};
`endif

    int m_p     = P_G1;
    int m_age   = 0;   // edges since phase entry, saturating at WAIT_CYC
    int m_left  = 0;   // ticks remaining once loaded
    bit m_pulse = 1'b0;
    int n_ped   = 0;
    int n_gx    = 0;

    function automatic int next_phase(input int p, input logic sens, input logic wr);
        case (p)
`ifdef TL_LONG_MAIN_EN
            P_G1:    return sens ? P_GX : P_Y;
`else
            P_G1:    return P_G2;
`endif
            P_G2:    return sens ? P_GX : P_Y;
            P_GX:    return P_Y;
            P_Y:     return wr ? P_PED : P_SG;
            P_PED:   return P_SG;
            P_SG:    return sens ? P_SGX : P_SY;
            P_SGX:   return P_SY;
            default: return P_G1;
        endcase
    endfunction

    // One clock edge of the model, using the inputs the DUT saw at that edge.
    task automatic model_edge(input logic rst, input logic prog, input logic tk,
                              input logic sens, input logic wr, input logic [CNT_W-1:0] v);
        m_pulse = 1'b0;
        if (rst || prog) begin
            m_p    = P_G1;
            m_age  = 0;
            m_left = 0;
        end else if (m_age < WAIT_CYC) begin
            m_age++;
            if (m_age == WAIT_CYC) m_left = (v == 0) ? 1 : int'(v);
        end else if (tk) begin
            if (m_left == 1) begin
                m_p   = next_phase(m_p, sens, wr);
                m_age = 0;
                if (m_p == P_PED) begin
                    m_pulse = 1'b1;
                    n_ped++;
                end
                if (m_p == P_GX || m_p == P_SGX) n_gx++;
            end else begin
                m_left--;
            end
        end
    endtask

    // ---------------- checking ----------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic prog, input logic tk,
                        input logic sens, input logic req);
        logic             wr_s;
        logic [CNT_W-1:0] v_s;
        @(negedge clk);
        Reset         = rst;
        Prog_Sync     = prog;
        one_hz_enable = tk;
        Sensor_Sync   = sens;
        wr_req        = req;
        @(posedge clk);
        wr_s = WR;
        v_s  = value;
        model_edge(rst, prog, tk, sens, wr_s, v_s);
        #1;
        check("main_lights", 32'(main_lights), 32'(tab_main[m_p]));
        check("side_lights", 32'(side_lights), 32'(tab_side[m_p]));
        check("interval",    32'(interval),    32'(tab_int[m_p]));
        check("walk",        32'(walk),        32'(m_p == P_PED));
        check("wr_reset",    32'(WR_Reset),    32'(m_pulse));
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        Reset = 1'b1; Prog_Sync = 1'b0; one_hz_enable = 1'b0; Sensor_Sync = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Defaults, no sensor, no walk, tick every 4 clocks.
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0, (i % 4) == 3, 1'b0, 1'b0);
        // Sensor held high.
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0, (i % 4) == 3, 1'b1, 1'b0);
        // Walk requests arriving now and then.
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0, (i % 4) == 3, 1'b0, (i % 37) == 5);
        // Tick every clock across phase changes.
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b1, i[4], (i % 50) == 10);
        // Reset, then Prog_Sync, each pulsed mid-sequence.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Zero-length yellow.
        t_yel = 0;
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, (i % 2) == 1, 1'b0, 1'b0);

        // Random traffic with occasional reprogramming of the duration table.
        for (int i = 0; i < 8000; i++) begin
            logic rst, prog;
            rst  = ($urandom_range(0, 499) == 0);
            prog = ($urandom_range(0, 499) == 0);
            if (rst || prog) begin
                t_base = $urandom_range(0, 15);
                t_ext  = $urandom_range(0, 15);
                t_yel  = $urandom_range(0, 15);
            end
            step(rst, prog, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0);
        end

        check("ped_reached", 32'(n_ped > 0), 32'd1);
        check("ext_reached", 32'(n_gx > 0),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
